result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning matrix dimension; legal range 2..16.
REQ-002 The block SHALL have parameter W, default 32, meaning element width in bits.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning reset; reset is synchronous and active-low.
REQ-005 The block SHALL have port in_value, input, W, meaning the result element from the multiplier.
REQ-006 The block SHALL have ports in_row and in_col, input, 5 each, meaning the destination row and column.
REQ-007 The block SHALL have port in_stb, input, 1, meaning the producer holds in_value/in_row/in_col valid.
REQ-008 The block SHALL have port in_ack, output, 1, meaning a one-cycle acceptance pulse.
REQ-009 The block SHALL have ports out_value (output, W), out_i and out_j (output, 5 each), meaning the element and index presented downstream.
REQ-010 The block SHALL have port out_stb, output, 1, meaning out_value/out_i/out_j are valid.
REQ-011 The block SHALL have port out_ack, input, 1, meaning a one-cycle consumer acceptance pulse.
REQ-012 The block SHALL have ports done and err, output, 1 each, meaning matrix fully drained (pulse) and sticky bad-index flag.

Function
REQ-013 The block SHALL implement states S_FILL, S_READ, S_PRESENT and S_DONE.
REQ-014 S_FILL: in_stb=1 and in_ack=0 at an edge SHALL accept; in_ack=1 for exactly the next cycle.
REQ-015 An accept with in_row<N and in_col<N SHALL write mem[in_row*N+in_col] and increment fill count.
REQ-016 An accept with in_row>=N or in_col>=N SHALL be acked, SHALL NOT write or count, and SHALL set err.
REQ-017 Rewriting an already-written cell SHALL overwrite its value and still count, i.e. the count counts accepts, not distinct cells.
REQ-018 When fill count reaches N*N on an accepting edge, the block SHALL enter S_READ at that edge with out_i=0 and out_j=0.
REQ-019 in_ack SHALL remain 0 in S_READ, S_PRESENT and S_DONE; in_stb in those states is held off, not dropped.
REQ-020 S_READ SHALL last one cycle, issuing a read at out_i*N+out_j, then enter S_PRESENT.
REQ-021 S_PRESENT SHALL drive out_stb=1 with out_value, out_i and out_j stable until out_ack=1 at an edge.
REQ-022 On out_ack in S_PRESENT, out_stb SHALL drop next cycle and the index SHALL advance row-major: j+1, wrapping to 0 with i+1.
REQ-023 After the ack of (N-1,N-1), the block SHALL enter S_DONE, with done=1 for one cycle, then S_FILL with count=0.
REQ-024 Otherwise, after an ack in S_PRESENT, the block SHALL return to S_READ, giving one bubble cycle between elements.
REQ-025 The first out_stb SHALL rise 2 cycles after the completing fill edge.
REQ-026 out_ack outside S_PRESENT SHALL be ignored.
REQ-027 err SHALL clear only on reset.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL enter S_FILL and set count=0, out_i=0, out_j=0, and in_ack, out_stb, done and err to 0.
REQ-029 Reset mid-fill or mid-drain SHALL abort the operation with no done pulse.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 out_value SHALL be don't-care while out_stb=0.

Structure
REQ-032 Package matmul_pkg SHALL hold N, W, the index width (5) and the state encoding, shared with the multiplier and file writer.
REQ-033 One sub-module, result_ram, SHALL provide N*N x W storage with synchronous write, one-cycle synchronous read and address width clog2(N*N).
REQ-034 The FSM, counters and handshake logic SHALL reside in result_buffer.

Verification
REQ-035 Fill N=2 with (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4 and ack each out_stb immediately -> outputs 1,2,3,4 with indices (0,0),(0,1),(1,0),(1,1); done pulses once; in_ack never exceeds 1 cycle.
REQ-036 Fill N=2 out of order with (1,1)=D, (0,0)=A, (1,0)=C, (0,1)=B -> drain order is A,B,C,D.
REQ-037 Stall out_ack for 5 cycles on element 2 -> out_value and indices stay stable; no skip or duplicate.
REQ-038 Present in_stb with (5,0) -> acked, err=1, count unchanged; a subsequent full fill still drains 4 elements.
REQ-039 Hold in_stb during drain -> in_ack=0 until after done; the held write is accepted at the first S_FILL cycle.
REQ-040 Assert rst_n=0 after 2 outputs -> no done, out_stb=0 next cycle, err=0; a fresh fill drains from (0,0).

Source files
------------

// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply datapath: the default matrix
// dimension and element width, the index width used on every row/column port,
// and the encoding of the result-buffer FSM states.
// No ports; imported by result_buffer, result_ram's users, the multiplier and
// the file writer.
// -----------------------------------------------------------------------------
package matmul_pkg;

   // Default matrix dimension (legal 2..16) and element width.
   localparam int MM_N  = 8;
   localparam int MM_W  = 32;

   // Row/column index width on all interfaces; covers N up to 16 plus
   // out-of-range values that must be detected and flagged.
   localparam int IDX_W = 5;

   // Result-buffer FSM state encoding.
   localparam logic [1:0] S_FILL    = 2'd0;
   localparam logic [1:0] S_READ    = 2'd1;
   localparam logic [1:0] S_PRESENT = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/result_ram.sv
// -----------------------------------------------------------------------------
// result_ram
// Single-port-write / single-port-read storage for one result matrix,
// DEPTH words of W bits. Writes are synchronous; reads are registered and the
// read data holds its value while i_rd_en is low.
// Ports:
//   clk        rising-edge clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe; o_rd_data updates on the following edge
//   i_rd_addr  read address
//   o_rd_data  registered read data
// -----------------------------------------------------------------------------
module result_ram #(
   parameter int DEPTH = 64,
   parameter int W     = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_rd_data
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rd_data;

   // NOTE: the storage array has no reset so it maps onto RAM macros; every
   // cell is written before it is read in normal operation.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/result_buffer.sv
// -----------------------------------------------------------------------------
// result_buffer
// Collects N*N result elements from the multiplier in any order, then drains
// them downstream in row-major order with a strobe/ack handshake.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   in_value/in_row/in_col/in_stb  producer element, destination and valid
//   in_ack                one-cycle acceptance pulse to the producer
//   out_value/out_i/out_j/out_stb  element and index presented downstream
//   out_ack               one-cycle acceptance pulse from the consumer
//   done                  one-cycle pulse after the last element is taken
//   err                   sticky flag: an out-of-range index was received
// -----------------------------------------------------------------------------
module result_buffer
   import matmul_pkg::*;
#(
   parameter int N = MM_N,
   parameter int W = MM_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     in_value,
   input  logic [IDX_W-1:0] in_row,
   input  logic [IDX_W-1:0] in_col,
   input  logic             in_stb,
   output logic             in_ack,
   output logic [W-1:0]     out_value,
   output logic [IDX_W-1:0] out_i,
   output logic [IDX_W-1:0] out_j,
   output logic             out_stb,
   input  logic             out_ack,
   output logic             done,
   output logic             err
);

   localparam int AW = $clog2(N * N);
   localparam int CW = $clog2(N * N + 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
   localparam logic [CW-1:0]    LAST_COUNT = CW'(N * N - 1);

   logic [1:0]       r_state;
   logic [CW-1:0]    r_count;
   logic             r_in_ack;
   logic             r_err;
   logic [IDX_W-1:0] r_out_i;
   logic [IDX_W-1:0] r_out_j;

   logic             w_accept;
   logic             w_in_range;
   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_last;
   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_rd_addr;

   // A strobe is taken only on an edge where no ack is pending, so a producer
   // that holds in_stb through its own ack cycle is not accepted twice.
   assign w_accept   = (r_state == S_FILL) && in_stb && !r_in_ack;
   assign w_in_range = (in_row <= LAST_IDX) && (in_col <= LAST_IDX);
   assign w_wr_en    = w_accept && w_in_range;
   assign w_rd_en    = (r_state == S_READ);
   assign w_last     = (r_out_i == LAST_IDX) && (r_out_j == LAST_IDX);

   assign w_wr_addr  = AW'(int'(in_row) * N + int'(in_col));
   assign w_rd_addr  = AW'(int'(r_out_i) * N + int'(r_out_j));

   result_ram #(
      .DEPTH (N * N),
      .W     (W),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (in_value),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (out_value)
   );

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_FILL;
         r_count  <= '0;
         r_in_ack <= 1'b0;
         r_err    <= 1'b0;
         r_out_i  <= '0;
         r_out_j  <= '0;
      end else begin
         // The ack for the completing element lands in the first S_READ
         // cycle; no new accept can start outside S_FILL.
         r_in_ack <= w_accept;
         if (w_accept && !w_in_range) begin
            r_err <= 1'b1;
         end

         case (r_state)
            S_FILL: begin
               if (w_wr_en) begin
                  r_count <= r_count + CW'(1);
                  if (r_count == LAST_COUNT) begin
                     r_state <= S_READ;
                     r_out_i <= '0;
                     r_out_j <= '0;
                  end
               end
            end
            S_READ: begin
               r_state <= S_PRESENT;
            end
            S_PRESENT: begin
               if (out_ack) begin
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_READ;
                     if (r_out_j == LAST_IDX) begin
                        r_out_j <= '0;
                        r_out_i <= r_out_i + IDX_W'(1);
                     end else begin
                        r_out_j <= r_out_j + IDX_W'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               r_state <= S_FILL;
               r_count <= '0;
               r_out_i <= '0;
               r_out_j <= '0;
            end
            default: begin
               r_state <= S_FILL;
            end
         endcase
      end
   end

   assign in_ack  = r_in_ack;
   assign out_i   = r_out_i;
   assign out_j   = r_out_j;
   assign out_stb = (r_state == S_PRESENT);
   assign done    = (r_state == S_DONE);
   assign err     = r_err;

endmodule

// File: tb/tb_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_result_buffer
// Self-checking bench for result_buffer at N=2. A matrix-level model keeps the
// expected contents as a 2-D array and derives the drain order by walking rows
// then columns.
// -----------------------------------------------------------------------------
module tb_result_buffer;

   localparam int TB_N = 2;
   localparam int TB_W = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [TB_W-1:0] in_value;
   logic [4:0]      in_row;
   logic [4:0]      in_col;
   logic            in_stb;
   logic            in_ack;
   logic [TB_W-1:0] out_value;
   logic [4:0]      out_i;
   logic [4:0]      out_j;
   logic            out_stb;
   logic            out_ack;
   logic            done;
   logic            err;

   int checks   = 0;
   int failures = 0;

   // Reference model: matrix contents, accepts in the current fill, err flag.
   logic [TB_W-1:0] m_mat [TB_N][TB_N];
   int              m_count;
   logic            m_err;

   result_buffer #(.N(TB_N), .W(TB_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_value  (in_value),
      .in_row    (in_row),
      .in_col    (in_col),
      .in_stb    (in_stb),
      .in_ack    (in_ack),
      .out_value (out_value),
      .out_i     (out_i),
      .out_j     (out_j),
      .out_stb   (out_stb),
      .out_ack   (out_ack),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Producer transaction; updates the model with the acceptance rules.
   task automatic send(input int row, input int col, input logic [TB_W-1:0] val);
      int n;
      in_row   = 5'(row);
      in_col   = 5'(col);
      in_value = val;
      in_stb   = 1'b1;
      n = 0;
      while (in_ack !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (in_ack !== 1'b1) begin
         failures++;
         $display("FAIL send_ack_timeout: in_ack=%b required 1 for (%0d,%0d)", in_ack, row, col);
         in_stb = 1'b0;
         return;
      end
      if (row < TB_N && col < TB_N) begin
         m_mat[row][col] = val;
         m_count++;
      end else begin
         m_err = 1'b1;
      end
      checks++;
      if (err !== m_err) begin
         failures++;
         $display("FAIL send_err: err=%b required %b after (%0d,%0d)", err, m_err, row, col);
      end
      checks++;
      if (out_stb !== 1'b0) begin
         failures++;
         $display("FAIL send_out_stb_early: out_stb=%b required 0", out_stb);
      end
      in_stb = 1'b0;
      tick();
      checks++;
      if (in_ack !== 1'b0) begin
         failures++;
         $display("FAIL in_ack_pulse: in_ack=%b required 0 one cycle after ack", in_ack);
      end
   endtask

   // Consumer: takes every element in row-major order from the model.
   task automatic drain(input int stall_at, input int stall_cycles, input bit noise);
      int done_seen;
      int n;
      bit last;
      done_seen = 0;
      for (int r = 0; r < TB_N; r++) begin
         for (int c = 0; c < TB_N; c++) begin
            n = 0;
            while (out_stb !== 1'b1 && n < 20) begin
               if (done === 1'b1) done_seen++;
               out_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
               tick();
               n++;
            end
            out_ack = 1'b0;
            checks++;
            if (out_stb !== 1'b1) begin
               failures++;
               $display("FAIL drain_timeout: out_stb=%b required 1 for (%0d,%0d)", out_stb, r, c);
               return;
            end
            for (int s = 0; s <= ((r * TB_N + c == stall_at) ? stall_cycles : 0); s++) begin
               if (s > 0) tick();
               checks++;
               if (out_stb !== 1'b1 || out_value !== m_mat[r][c] ||
                   out_i !== 5'(r) || out_j !== 5'(c)) begin
                  failures++;
                  $display("FAIL drain_elem: stb=%b val=%0h i=%0d j=%0d required stb=1 val=%0h i=%0d j=%0d (stall %0d)",
                           out_stb, out_value, out_i, out_j, m_mat[r][c], r, c, s);
               end
               checks++;
               if (in_ack !== 1'b0) begin
                  failures++;
                  $display("FAIL drain_in_ack: in_ack=%b required 0 while draining", in_ack);
               end
            end
            out_ack = 1'b1;
            tick();
            out_ack = 1'b0;
            last = (r == TB_N - 1) && (c == TB_N - 1);
            if (done === 1'b1) done_seen++;
            checks++;
            if (out_stb !== 1'b0 || done !== last || in_ack !== 1'b0) begin
               failures++;
               $display("FAIL after_ack: stb=%b done=%b in_ack=%b required stb=0 done=%b in_ack=0",
                        out_stb, done, in_ack, last);
            end
         end
      end
      tick();
      checks++;
      if (done !== 1'b0 || done_seen != 1) begin
         failures++;
         $display("FAIL done_pulse: done=%b pulses=%0d required done=0 pulses=1", done, done_seen);
      end
      m_count = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (in_ack !== 1'b0 || out_stb !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          out_i !== 5'd0 || out_j !== 5'd0) begin
         failures++;
         $display("FAIL reset_state: in_ack=%b out_stb=%b done=%b err=%b i=%0d j=%0d required all 0",
                  in_ack, out_stb, done, err, out_i, out_j);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (out_stb !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: out_stb=%b done=%b required 0 0", out_stb, done);
      end
      m_count = 0;
      m_err   = 1'b0;
   endtask

   task automatic test_basic();
      send(0, 0, 32'd1);
      send(0, 1, 32'd2);
      send(1, 0, 32'd3);
      send(1, 1, 32'd4);
      checks++;
      if (out_stb !== 1'b1) begin
         failures++;
         $display("FAIL first_stb_latency: out_stb=%b required 1 two cycles after fill", out_stb);
      end
      drain(-1, 0, 1'b0);
   endtask

   task automatic test_out_of_order();
      send(1, 1, $urandom);
      send(0, 0, $urandom);
      send(1, 0, $urandom);
      send(0, 1, $urandom);
      drain(-1, 0, 1'b0);
   endtask

   task automatic test_stall();
      for (int k = 0; k < TB_N * TB_N; k++) send(k / TB_N, k % TB_N, $urandom);
      drain(1, 5, 1'b0);
   endtask

   task automatic test_bad_index();
      send(5, 0, 32'hDEAD_BEEF);
      for (int k = 0; k < TB_N * TB_N - 1; k++) send(k / TB_N, k % TB_N, $urandom);
      for (int s = 0; s < 3; s++) begin
         tick();
         checks++;
         if (out_stb !== 1'b0) begin
            failures++;
            $display("FAIL bad_index_counted: out_stb=%b required 0 before last valid element", out_stb);
         end
      end
      send(TB_N - 1, TB_N - 1, $urandom);
      drain(-1, 0, 1'b0);
   endtask

   task automatic test_hold_during_drain();
      logic [TB_W-1:0] held;
      for (int k = 0; k < TB_N * TB_N; k++) send(k / TB_N, k % TB_N, $urandom);
      held     = $urandom;
      in_row   = 5'd0;
      in_col   = 5'd1;
      in_value = held;
      in_stb   = 1'b1;
      drain(-1, 0, 1'b0);
      checks++;
      if (in_ack !== 1'b0) begin
         failures++;
         $display("FAIL hold_first_fill_cycle: in_ack=%b required 0", in_ack);
      end
      tick();
      checks++;
      if (in_ack !== 1'b1) begin
         failures++;
         $display("FAIL hold_accept: in_ack=%b required 1 after first fill cycle", in_ack);
      end
      in_stb = 1'b0;
      m_mat[0][1] = held;
      m_count = 1;
      tick();
      send(0, 0, $urandom);
      send(1, 0, $urandom);
      send(1, 1, $urandom);
      drain(-1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_drain();
      int n;
      for (int k = 0; k < TB_N * TB_N; k++) send(k / TB_N, k % TB_N, $urandom);
      for (int e = 0; e < 3; e++) begin
         n = 0;
         while (out_stb !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         checks++;
         if (out_stb !== 1'b1 || out_value !== m_mat[e / TB_N][e % TB_N]) begin
            failures++;
            $display("FAIL partial_drain: stb=%b val=%0h required stb=1 val=%0h",
                     out_stb, out_value, m_mat[e / TB_N][e % TB_N]);
         end
         if (e < 2) begin
            out_ack = 1'b1;
            tick();
            out_ack = 1'b0;
         end
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (out_stb !== 1'b0 || done !== 1'b0 || err !== 1'b0 || in_ack !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: stb=%b done=%b err=%b in_ack=%b required all 0",
                  out_stb, done, err, in_ack);
      end
      rst_n = 1'b1;
      m_count = 0;
      m_err   = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_done: done=%b required 0", done);
      end
      send(1, 0, $urandom);
      send(0, 1, $urandom);
      send(1, 1, $urandom);
      send(0, 0, $urandom);
      drain(-1, 0, 1'b0);
   endtask

   task automatic test_random();
      int row;
      int col;
      for (int round = 0; round < 20; round++) begin
         while (m_count < TB_N * TB_N) begin
            row = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 31)) : int'($urandom_range(0, TB_N - 1));
            col = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 31)) : int'($urandom_range(0, TB_N - 1));
            send(row, col, $urandom);
            repeat ($urandom_range(0, 2)) tick();
         end
         drain(int'($urandom_range(0, TB_N * TB_N - 1)), int'($urandom_range(0, 3)), 1'b1);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_stb   = 1'b0;
      in_value = '0;
      in_row   = '0;
      in_col   = '0;
      out_ack  = 1'b0;
      m_count  = 0;
      m_err    = 1'b0;
      test_reset();
      test_basic();
      test_out_of_order();
      test_stall();
      test_bad_index();
      test_hold_during_drain();
      test_reset_mid_drain();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
